decode_ctrl_queue: RTL

//  Registered, parametrised RV32I control decoder with an output queue, sitting between fetch and

---
 rtl/decode_ctrl_queue.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_queue.sv
// RV32I control decoder feeding an in-order queue of decoded bundles, between fetch and execute.
// Build option: define DECODE_MEXT_EN to decode RV32M (OP opcode, funct7=0000001) into md_op.

module alu_decoder (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [3:0] alu_control
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b00: alu_control = ALU_ADD;
            2'b01: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // Only the register form may subtract; ADDI reuses bit 30 as immediate.
                    3'b000:  alu_control = (funct7_5 && op_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
        endcase
    end
endmodule

module decode_ctrl_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [3:0]        alu_control,
    output logic              alu_src_a,
    output logic              alu_src_b,
    output logic              mem_write,
    output logic              reg_write,
    output logic [1:0]        result_src,
    output logic [2:0]        imm_src,
    output logic [1:0]        mem_size,
    output logic              mem_signed,
    output logic              pc_target_src,
    output logic              branch,
    output logic              jump,
    output logic [2:0]        branch_type,
    output logic [3:0]        md_op,
    output logic              illegal,
    output logic [CNT_W-1:0]  decode_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] DEC_ONE  = CNT_W'(1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [1:0] mem_size;
        logic       mem_signed;
        logic       pc_target_src;
        logic       branch;
        logic       jump;
        logic [2:0] branch_type;
        logic [3:0] md_op;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] alu_op;
    logic [3:0] alu_ctl;
    logic       legal;
    ctrl_t      dec_base;
    ctrl_t      dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // NOTE: every signal written in this block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        dec_base          = '0;
        dec_base.mem_size = 2'b10;
        alu_op            = 2'b00;
        legal             = 1'b1;
        case (opcode)
            OP_R: begin
                dec_base.reg_write = 1'b1;
                alu_op             = 2'b10;
                if (funct7 == 7'b0000001) begin
`ifdef DECODE_MEXT_EN
                    dec_base.md_op = {1'b1, funct3};
`else
                    legal = 1'b0;
`endif
                end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    legal = 1'b0;
                end
            end
            OP_I_ALU: begin
                dec_base.reg_write = 1'b1;
                dec_base.alu_src_b = 1'b1;
                alu_op             = 2'b10;
            end
            OP_LOAD: begin
                dec_base.reg_write  = 1'b1;
                dec_base.result_src = 2'b01;
                dec_base.alu_src_b  = 1'b1;
                case (funct3)
                    3'b000:  begin dec_base.mem_size = 2'b00; dec_base.mem_signed = 1'b1; end
                    3'b001:  begin dec_base.mem_size = 2'b01; dec_base.mem_signed = 1'b1; end
                    3'b010:  dec_base.mem_size = 2'b10;
                    3'b100:  dec_base.mem_size = 2'b00;
                    3'b101:  dec_base.mem_size = 2'b01;
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                dec_base.mem_write = 1'b1;
                dec_base.alu_src_b = 1'b1;
                dec_base.imm_src   = 3'b001;
                dec_base.mem_size  = funct3[1:0];
                if (funct3 > 3'b010) legal = 1'b0;
            end
            OP_BRANCH: begin
                dec_base.branch      = 1'b1;
                dec_base.imm_src     = 3'b010;
                dec_base.branch_type = funct3;
                alu_op               = 2'b01;
            end
            OP_LUI: begin
                dec_base.reg_write = 1'b1;
                dec_base.alu_src_b = 1'b1;
                dec_base.imm_src   = 3'b011;
            end
            OP_AUIPC: begin
                dec_base.reg_write = 1'b1;
                dec_base.alu_src_a = 1'b1;
                dec_base.alu_src_b = 1'b1;
                dec_base.imm_src   = 3'b011;
            end
            OP_JAL: begin
                dec_base.reg_write  = 1'b1;
                dec_base.result_src = 2'b10;
                dec_base.imm_src    = 3'b100;
                dec_base.jump       = 1'b1;
            end
            OP_JALR: begin
                dec_base.reg_write     = 1'b1;
                dec_base.result_src    = 2'b10;
                dec_base.alu_src_b     = 1'b1;
                dec_base.jump          = 1'b1;
                dec_base.pc_target_src = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal words carry a fully zeroed bundle so nothing downstream can act on them.
        if (!legal) begin
            dec_base         = '0;
            dec_base.illegal = 1'b1;
            alu_op           = 2'b00;
        end
        if (in_instr[11:7] == 5'd0) dec_base.reg_write = 1'b0;
    end

    alu_decoder u_alu_decoder (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7_5   (in_instr[30]),
        .op_5       (in_instr[5]),
        .alu_control(alu_ctl)
    );

    always_comb begin
        dec             = dec_base;
        dec.alu_control = alu_ctl;
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] decode_count_q, decode_count_d;
    entry_t           entry_q [DEPTH];
    entry_t           head;
    logic             push, pop;

    assign in_ready  = !rst && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        decode_count_d = decode_count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_d       = rd_ptr_q + PTR_ONE;
                decode_count_d = decode_count_q + DEC_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            decode_count_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            decode_count_q <= decode_count_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; count_q gates every read, so stale
    // contents are never observed and the array can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push) entry_q[wr_ptr_q] <= '{ctrl: dec, instr: in_instr, pc: in_pc};
    end

    always_comb begin
        head = '0;
        if (out_valid) head = entry_q[rd_ptr_q];
    end

    assign out_instr     = head.instr;
    assign out_pc        = head.pc;
    assign alu_control   = head.ctrl.alu_control;
    assign alu_src_a     = head.ctrl.alu_src_a;
    assign alu_src_b     = head.ctrl.alu_src_b;
    assign mem_write     = head.ctrl.mem_write;
    assign reg_write     = head.ctrl.reg_write;
    assign result_src    = head.ctrl.result_src;
    assign imm_src       = head.ctrl.imm_src;
    assign mem_size      = head.ctrl.mem_size;
    assign mem_signed    = head.ctrl.mem_signed;
    assign pc_target_src = head.ctrl.pc_target_src;
    assign branch        = head.ctrl.branch;
    assign jump          = head.ctrl.jump;
    assign branch_type   = head.ctrl.branch_type;
    assign md_op         = head.ctrl.md_op;
    assign illegal       = head.ctrl.illegal;
    assign decode_count  = decode_count_q;
endmodule
